// File: rtl/quad_gate_tester.sv
// Functional tester for a 14-pin quad 2-input gate chip: sweeps all 256 input
// vectors, waits a settle time per vector, and tallies mismatching gate outputs.
//
// state  | meaning
// IDLE   | waiting for i_start; results from the last run held
// SETTLE | vector driven, settle counter running
// CHECK  | compare chip outputs against the expected function
// DONE   | one-cycle end-of-run pulse, pins released to 0
module quad_gate_tester #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [2:0] i_func,
    input  logic       i_stop_on_fail,
    output logic       o_pin1,
    output logic       o_pin2,
    output logic       o_pin4,
    output logic       o_pin5,
    output logic       o_pin9,
    output logic       o_pin10,
    output logic       o_pin12,
    output logic       o_pin13,
    input  logic       i_pin3,
    input  logic       i_pin6,
    input  logic       i_pin8,
    input  logic       i_pin11,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic       o_err,
    output logic [8:0] o_fail_cnt,
    output logic [7:0] o_fail_vec,
    output logic [3:0] o_gate_fail
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [2:0] FUNC_MAX    = 3'd4;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    logic [1:0] state_q, state_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] func_q, func_d;
    logic       stop_q, stop_d;
    logic       pass_q, pass_d;
    logic       err_q, err_d;
    logic [8:0] fail_cnt_q, fail_cnt_d;
    logic [7:0] fail_vec_q, fail_vec_d;
    logic [3:0] gate_fail_q, gate_fail_d;

    logic [3:0] exp_out;
    logic [3:0] act_out;
    logic [3:0] mismatch;
    logic       busy;

    function automatic logic gate_f(input logic [2:0] f, input logic a, input logic b);
        logic r;
        case (f)
            3'd0:    r = a & b;
            3'd1:    r = ~(a & b);
            3'd2:    r = a | b;
            3'd3:    r = ~(a | b);
            3'd4:    r = a ^ b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Gate g is fed by vector bits 2g and 2g+1.
    always_comb begin
        exp_out[0] = gate_f(func_q, vec_q[0], vec_q[1]);
        exp_out[1] = gate_f(func_q, vec_q[2], vec_q[3]);
        exp_out[2] = gate_f(func_q, vec_q[4], vec_q[5]);
        exp_out[3] = gate_f(func_q, vec_q[6], vec_q[7]);
    end

    assign act_out  = {i_pin11, i_pin8, i_pin6, i_pin3};
    assign mismatch = act_out ^ exp_out;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        func_d      = func_q;
        stop_d      = stop_q;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_cnt_d  = fail_cnt_q;
        fail_vec_d  = fail_vec_q;
        gate_fail_d = gate_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_func <= FUNC_MAX) begin
                        func_d      = i_func;
                        stop_d      = i_stop_on_fail;
                        vec_d       = 8'd0;
                        fail_cnt_d  = 9'd0;
                        fail_vec_d  = 8'd0;
                        gate_fail_d = 4'd0;
                        pass_d      = 1'b0;
                        err_d       = 1'b0;
                        cnt_d       = SETTLE_LOAD;
                        state_d     = ST_SETTLE;
                    end else begin
                        err_d   = 1'b1;
                        pass_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                if (|mismatch) begin
                    fail_cnt_d  = fail_cnt_q + 9'd1;
                    gate_fail_d = gate_fail_q | mismatch;
                    if (fail_cnt_q == 9'd0) begin
                        fail_vec_d = vec_q;
                    end
                end
                // pass is resolved on entry to DONE so it is valid alongside o_done
                if ((vec_q == 8'hFF) || ((|mismatch) && stop_q)) begin
                    pass_d  = (fail_cnt_d == 9'd0) && !err_q;
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 8'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= 8'd0;
            cnt_q       <= 8'd0;
            func_q      <= 3'd0;
            stop_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
            fail_cnt_q  <= 9'd0;
            fail_vec_q  <= 8'd0;
            gate_fail_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            stop_q      <= stop_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_vec_q  <= fail_vec_d;
            gate_fail_q <= gate_fail_d;
        end
    end

    assign busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);

    assign o_pin1  = busy & vec_q[0];
    assign o_pin2  = busy & vec_q[1];
    assign o_pin4  = busy & vec_q[2];
    assign o_pin5  = busy & vec_q[3];
    assign o_pin9  = busy & vec_q[4];
    assign o_pin10 = busy & vec_q[5];
    assign o_pin12 = busy & vec_q[6];
    assign o_pin13 = busy & vec_q[7];

    assign o_busy      = busy;
    assign o_done      = (state_q == ST_DONE);
    assign o_pass      = pass_q;
    assign o_err       = err_q;
    assign o_fail_cnt  = fail_cnt_q;
    assign o_fail_vec  = fail_vec_q;
    assign o_gate_fail = gate_fail_q;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Bench for quad_gate_tester: a behavioural chip model with stuck-at faults and
// a sweep-level reference for counts, masks, first failing vector and run length.
module tb_quad_gate_tester;

    localparam int S    = 4;
    localparam int FULL = 256 * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] func = 3'd0;
    logic       stop = 1'b0;
    logic       p1, p2, p4, p5, p9, p10, p12, p13;
    logic       p3, p6, p8, p11;
    logic       busy, done, pass, err;
    logic [8:0] fail_cnt;
    logic [7:0] fail_vec;
    logic [3:0] gate_fail;

    logic [2:0] chip_func = 3'd0;
    logic [3:0] stuck0 = 4'd0;
    logic [3:0] stuck1 = 4'd0;

    int checks = 0;
    int errors = 0;

    quad_gate_tester #(.SETTLE_CYCLES(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_func(func),
        .i_stop_on_fail(stop),
        .o_pin1(p1), .o_pin2(p2), .o_pin4(p4), .o_pin5(p5),
        .o_pin9(p9), .o_pin10(p10), .o_pin12(p12), .o_pin13(p13),
        .i_pin3(p3), .i_pin6(p6), .i_pin8(p8), .i_pin11(p11),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err(err),
        .o_fail_cnt(fail_cnt), .o_fail_vec(fail_vec), .o_gate_fail(gate_fail)
    );

    always #5 clk = ~clk;

    // Gate truth by counting high inputs.
    function automatic logic gate(input logic [2:0] f, input logic a, input logic b);
        int n;
        n = int'(a) + int'(b);
        case (f)
            3'd0:    return n == 2;
            3'd1:    return n != 2;
            3'd2:    return n >= 1;
            3'd3:    return n == 0;
            3'd4:    return n == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] chip_out(input logic [7:0] v, input logic [2:0] f,
                                            input logic [3:0] s0, input logic [3:0] s1);
        logic [3:0] r;
        for (int g = 0; g < 4; g++) begin
            r[g] = gate(f, v[2*g], v[2*g+1]);
            if (s0[g]) r[g] = 1'b0;
            if (s1[g]) r[g] = 1'b1;
        end
        return r;
    endfunction

    logic [7:0] pins_v;
    logic [3:0] chip_v;
    always_comb begin
        pins_v = {p13, p12, p10, p9, p5, p4, p2, p1};
        chip_v = chip_out(pins_v, chip_func, stuck0, stuck1);
        p3  = chip_v[0];
        p6  = chip_v[1];
        p8  = chip_v[2];
        p11 = chip_v[3];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_run(input logic [2:0] f, input logic st, output int cnt,
                           output logic [3:0] gf, output logic [7:0] fv, output int cyc);
        logic [3:0] m;
        cnt = 0; gf = 4'd0; fv = 8'd0; cyc = FULL;
        for (int v = 0; v < 256; v++) begin
            m = chip_out(8'(v), chip_func, stuck0, stuck1) ^ chip_out(8'(v), f, 4'd0, 4'd0);
            if (m != 4'd0) begin
                if (cnt == 0) fv = 8'(v);
                cnt++;
                gf |= m;
                if (st) begin
                    cyc = (v + 1) * (S + 1);
                    break;
                end
            end
        end
    endtask

    task automatic do_run(input string tag, input logic [2:0] f, input logic st, input bit disturb);
        int e_cnt, e_cyc, n;
        logic [3:0] e_gf;
        logic [7:0] e_fv;
        bit busy_ok;
        ref_run(f, st, e_cnt, e_gf, e_fv, e_cyc);
        @(negedge clk);
        rst_n = 1'b1; func = f; stop = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = busy;
        n = 0;
        while (n < 70000) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (!busy) busy_ok = 0;
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                func = 3'($urandom);
                stop = 1'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_cycles"}, 64'(n), 64'(e_cyc));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(e_cnt));
        check({tag, "_gate_fail"}, 64'(gate_fail), 64'(e_gf));
        check({tag, "_fail_vec"}, 64'(fail_vec), 64'(e_fv));
        check({tag, "_pass"}, 64'(pass), 64'(e_cnt == 0));
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_pins_done"}, 64'(pins_v), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 64'({done, busy}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold"}, 64'({pass, fail_cnt, gate_fail, fail_vec}),
              64'({1'(e_cnt == 0), 9'(e_cnt), e_gf, e_fv}));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, pass, err, fail_cnt, fail_vec, gate_fail, pins_v});
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", all_outs(), 64'd0);

        // Good AND chip, with no settle-time disturbance first.
        chip_func = 3'd0; stuck0 = 4'd0; stuck1 = 4'd0;
        do_run("and_ok", 3'd0, 1'b0, 1'b0);

        stuck0 = 4'b0100;
        do_run("pin8_s0", 3'd0, 1'b0, 1'b0);
        check("pin8_s0_vec", 64'(fail_vec), 64'h30);

        stuck0 = 4'd0;
        do_run("and_as_xor", 3'd4, 1'b0, 1'b0);

        stuck1 = 4'b0001;
        do_run("stop_pin3_s1", 3'd0, 1'b1, 1'b0);
        stuck1 = 4'd0;

        // Reserved function: immediate DONE with err.
        @(negedge clk);
        func = 3'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rsvd_done", 64'({done, err, pass, busy}), 64'b1100);
        @(posedge clk); #1;
        check("rsvd_after", 64'({done, err, pass, busy}), 64'b0100);

        // Reset in the middle of a run at vector 100.
        @(negedge clk);
        func = 3'd0; stop = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(busy && pins_v == 8'd100) && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_vec100", 64'(busy && pins_v == 8'd100), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset", all_outs(), 64'd0);
        @(posedge clk); #1;
        check("midrun_reset_nodone", 64'(done), 64'd0);
        do_run("after_reset", 3'd0, 1'b0, 1'b0);

        // Randomised chips, functions and fault patterns with mid-run noise.
        for (int r = 0; r < 6; r++) begin
            chip_func = 3'($urandom_range(0, 4));
            stuck0 = 4'($urandom) & 4'($urandom);
            stuck1 = 4'($urandom) & 4'($urandom) & ~stuck0;
            do_run($sformatf("rand%0d", r), 3'($urandom_range(0, 4)), 1'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
